// File: rtl/twiddle_cmult.sv
// Twiddle address generator and complex multiplier for the 256-point DIF FFT.
// Issues one ROM read per sample and returns sample * twiddle after 3 cycles.
module twiddle_cmult #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 In_Valid,
   input  logic                 In_Sop,
   input  logic [2*WIDTH-1:0]   In_Data,
   input  logic [2:0]           Stage,
   input  logic                 Inv,
   output logic                 Tw_En,
   output logic [ADDR_W-1:0]    Tw_Addr,
   input  logic [2*WIDTH-1:0]   Tw_Data,
   output logic                 Out_Valid,
   output logic                 Out_Sop,
   output logic [2*WIDTH-1:0]   Out_Data,
   output logic                 Out_Ovf
);

   localparam int PW   = WIDTH + 10;
   localparam int SW   = WIDTH + 11;
   localparam int MAXI = (1 << (WIDTH - 1)) - 1;
   localparam int MINI = -(1 << (WIDTH - 1));
   localparam logic signed [SW-1:0] MAXV = SW'(MAXI);
   localparam logic signed [SW-1:0] MINV = SW'(MINI);
   localparam logic [ADDR_W-1:0] HALF0 = ADDR_W'(1) << (ADDR_W - 1);

   logic                 sop_acc;
   logic [2:0]           stage_eff;
   logic                 inv_eff;
   logic [ADDR_W-1:0]    half;
   logic [ADDR_W-1:0]    j;
   logic [ADDR_W-1:0]    j_inc;

   logic [2:0]           stage_q, stage_d;
   logic                 inv_q, inv_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;

   always_comb begin
      sop_acc   = In_Valid & In_Sop;
      stage_eff = sop_acc ? Stage : stage_q;
      inv_eff   = sop_acc ? Inv : inv_q;
      half      = HALF0 >> stage_eff;
      j         = sop_acc ? '0 : idx_q;
      j_inc     = j + ADDR_W'(1);
      idx_d     = idx_q;
      if (In_Valid) begin
         idx_d = (j_inc == half) ? '0 : j_inc;
      end
      stage_d   = stage_eff;
      inv_d     = inv_eff;
      Tw_En     = In_Valid;
      Tw_Addr   = j << stage_eff;
   end

   logic                 v1_q, sop1_q, inv1_q;
   logic [2*WIDTH-1:0]   d1_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         stage_q <= '0;
         inv_q   <= 1'b0;
         idx_q   <= '0;
         v1_q    <= 1'b0;
         sop1_q  <= 1'b0;
         inv1_q  <= 1'b0;
         d1_q    <= '0;
      end else begin
         stage_q <= stage_d;
         inv_q   <= inv_d;
         idx_q   <= idx_d;
         v1_q    <= In_Valid;
         sop1_q  <= sop_acc;
         inv1_q  <= inv_eff;
         if (In_Valid) begin
            d1_q <= In_Data;
         end
      end
   end

   // Magnitudes above 1.0 cannot occur in a valid table; clamp them to 1.0.
   function automatic logic signed [9:0] sm_to_tc(input logic [15:0] h);
      logic [9:0] m;
      m = (h[14:0] > 15'd256) ? 10'd256 : h[9:0];
      return h[15] ? -$signed(m) : $signed(m);
   endfunction

   logic signed [WIDTH-1:0] xr, xi;
   logic signed [9:0]       tw_c, tw_s;
   logic signed [PW-1:0]    xrc_d, xis_d, xic_d, xrs_d;

   always_comb begin
      xr    = $signed(d1_q[2*WIDTH-1:WIDTH]);
      xi    = $signed(d1_q[WIDTH-1:0]);
      tw_c  = sm_to_tc(Tw_Data[2*WIDTH-1:WIDTH]);
      tw_s  = sm_to_tc(Tw_Data[WIDTH-1:0]);
      xrc_d = PW'(xr) * PW'(tw_c);
      xis_d = PW'(xi) * PW'(tw_s);
      xic_d = PW'(xi) * PW'(tw_c);
      xrs_d = PW'(xr) * PW'(tw_s);
   end

   logic                 v2_q, sop2_q, inv2_q;
   logic signed [PW-1:0] xrc_q, xis_q, xic_q, xrs_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         v2_q   <= 1'b0;
         sop2_q <= 1'b0;
         inv2_q <= 1'b0;
         xrc_q  <= '0;
         xis_q  <= '0;
         xic_q  <= '0;
         xrs_q  <= '0;
      end else begin
         v2_q   <= v1_q;
         sop2_q <= sop1_q;
         inv2_q <= inv1_q;
         if (v1_q) begin
            xrc_q <= xrc_d;
            xis_q <= xis_d;
            xic_q <= xic_d;
            xrs_q <= xrs_d;
         end
      end
   end

   logic signed [SW-1:0] sum_re, sum_im;
   logic signed [SW-1:0] rnd_re, rnd_im;
   logic [WIDTH-1:0]     o_re, o_im;
   logic                 ovf_re, ovf_im;

   // Forward transform uses the conjugate twiddle (c - js).
   always_comb begin
      if (inv2_q) begin
         sum_re = SW'(xrc_q) - SW'(xis_q);
         sum_im = SW'(xic_q) + SW'(xrs_q);
      end else begin
         sum_re = SW'(xrc_q) + SW'(xis_q);
         sum_im = SW'(xic_q) - SW'(xrs_q);
      end
      rnd_re = (sum_re + SW'(128)) >>> 8;
      rnd_im = (sum_im + SW'(128)) >>> 8;
      ovf_re = 1'b0;
      ovf_im = 1'b0;
      o_re   = rnd_re[WIDTH-1:0];
      o_im   = rnd_im[WIDTH-1:0];
      if (rnd_re > MAXV) begin
         o_re   = MAXV[WIDTH-1:0];
         ovf_re = 1'b1;
      end else if (rnd_re < MINV) begin
         o_re   = MINV[WIDTH-1:0];
         ovf_re = 1'b1;
      end
      if (rnd_im > MAXV) begin
         o_im   = MAXV[WIDTH-1:0];
         ovf_im = 1'b1;
      end else if (rnd_im < MINV) begin
         o_im   = MINV[WIDTH-1:0];
         ovf_im = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Out_Valid <= 1'b0;
         Out_Sop   <= 1'b0;
         Out_Data  <= '0;
         Out_Ovf   <= 1'b0;
      end else begin
         Out_Valid <= v2_q;
         Out_Sop   <= v2_q & sop2_q;
         if (v2_q) begin
            Out_Data <= {o_re, o_im};
            Out_Ovf  <= ovf_re | ovf_im;
         end
      end
   end

endmodule

// File: tb/tb_twiddle_cmult.sv
// Randomized bench for twiddle_cmult with a behavioural ROM and
// a cycle-indexed expected-output model.
module tb_twiddle_cmult;

   localparam int NC = 8192;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        In_Valid, In_Sop, Inv;
   logic [31:0] In_Data;
   logic [2:0]  Stage;
   logic        Tw_En;
   logic [7:0]  Tw_Addr;
   logic [31:0] Tw_Data;
   logic        Out_Valid, Out_Sop, Out_Ovf;
   logic [31:0] Out_Data;

   always #5 Clk = ~Clk;

   twiddle_cmult #(.WIDTH(16), .ADDR_W(8)) dut (
      .Clk(Clk), .Rst(Rst),
      .In_Valid(In_Valid), .In_Sop(In_Sop), .In_Data(In_Data),
      .Stage(Stage), .Inv(Inv),
      .Tw_En(Tw_En), .Tw_Addr(Tw_Addr), .Tw_Data(Tw_Data),
      .Out_Valid(Out_Valid), .Out_Sop(Out_Sop),
      .Out_Data(Out_Data), .Out_Ovf(Out_Ovf)
   );

   logic [31:0] rom [256];
   logic [31:0] tw_q = '0;
   always @(posedge Clk) if (Tw_En) tw_q <= rom[Tw_Addr];
   assign Tw_Data = tw_q;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   function automatic logic [15:0] to_sm(input int v);
      return (v < 0) ? {1'b1, 15'(-v)} : {1'b0, 15'(v)};
   endfunction

   function automatic int sm2i(input logic [15:0] h);
      int mag;
      mag = int'(h[14:0]);
      if (mag > 256) mag = 256;
      return h[15] ? -mag : mag;
   endfunction

   function automatic int sat16(input int v, inout bit ovf);
      if (v > 32767) begin ovf = 1; return 32767; end
      if (v < -32768) begin ovf = 1; return -32768; end
      return v;
   endfunction

   // model state
   bit          ev [NC];
   bit          es [NC];
   bit          eo [NC];
   bit          erst [NC];
   logic [31:0] ed [NC];
   logic [31:0] last_d = '0;
   bit          last_o = 0;
   int          cyc = 0;
   int          m_idx = 0;
   int          m_stage = 0;
   bit          m_inv = 0;

   task automatic step(input bit v, input bit sop, input int xr, input int xi,
                       input int stg, input bit inv, input bit rst);
      int j, half, addr, c, s, re, im;
      bit ovf;
      if (cyc + 4 >= NC) begin
         $display("FAIL cycle_budget got=%0d exp<%0d", cyc, NC);
         $fatal(1);
      end
      In_Valid = v;
      In_Sop   = sop;
      In_Data  = {xr[15:0], xi[15:0]};
      Stage    = stg[2:0];
      Inv      = inv;
      Rst      = rst;
      #1;
      if (erst[cyc]) begin last_d = '0; last_o = 0; end
      if (ev[cyc]) begin last_d = ed[cyc]; last_o = eo[cyc]; end
      check("out_valid", Out_Valid, ev[cyc]);
      check("out_sop", Out_Sop, ev[cyc] & es[cyc]);
      check("out_data", Out_Data, last_d);
      check("out_ovf", Out_Ovf, last_o);
      check("tw_en", Tw_En, v);
      if (rst) begin
         for (int k = 1; k <= 3; k++) ev[cyc+k] = 0;
         erst[cyc+1] = 1;
         m_idx = 0; m_stage = 0; m_inv = 0;
      end else if (v) begin
         if (sop) begin m_stage = stg; m_inv = inv; j = 0; end
         else j = m_idx;
         half = 128 >> m_stage;
         addr = (j << m_stage) % 256;
         check("tw_addr", Tw_Addr, addr);
         m_idx = (j + 1 == half) ? 0 : j + 1;
         c = sm2i(rom[addr][31:16]);
         s = sm2i(rom[addr][15:0]);
         if (!m_inv) begin re = xr*c + xi*s; im = xi*c - xr*s; end
         else begin re = xr*c - xi*s; im = xi*c + xr*s; end
         ovf = 0;
         re = sat16((re + 128) >>> 8, ovf);
         im = sat16((im + 128) >>> 8, ovf);
         ev[cyc+3] = 1;
         es[cyc+3] = sop;
         eo[cyc+3] = ovf;
         ed[cyc+3] = {re[15:0], im[15:0]};
      end
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      real ang;
      int cr, ci;
      logic [15:0] r1, r2;
      for (int k = 0; k < 256; k++) begin
         ang = 2.0 * 3.14159265358979 * k / 256.0;
         cr = $rtoi($cos(ang) * 256.0 + (($cos(ang) < 0) ? -0.5 : 0.5));
         ci = $rtoi($sin(ang) * 256.0 + (($sin(ang) < 0) ? -0.5 : 0.5));
         rom[k] = {to_sm(cr), to_sm(ci)};
      end
      Rst = 1; In_Valid = 0; In_Sop = 0; In_Data = '0; Stage = '0; Inv = 0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      #1;
      check("rst_tw_addr", Tw_Addr, 0);
      erst[0] = 1;

      // unit twiddle at address 0
      step(1, 1, 100, -50, 0, 0, 0);
      idle(4);

      // quarter-turn twiddle, forward then inverse
      for (int iv = 0; iv < 2; iv++) begin
         for (int i = 0; i <= 64; i++) step(1, i == 0, 100, 0, 0, bit'(iv), 0);
         idle(3);
      end

      // stage 2 wrap, then stage 7 address pinned at 0; Stage changes without Sop ignored
      for (int i = 0; i < 40; i++) step(1, i == 0, i * 7, -i * 3, (i == 0) ? 2 : 5, 0, 0);
      for (int i = 0; i < 5; i++) step(1, i == 0, 1000, 2000, (i == 0) ? 7 : 1, i != 0, 0);
      idle(3);

      // saturation with a (181, -181) twiddle placed at address 0
      rom[0] = {to_sm(181), to_sm(-181)};
      step(1, 1, 32767, 32767, 0, 0, 0);
      idle(3);
      rom[0] = {to_sm(256), to_sm(0)};

      // bubbles: 1,0,1,1,0 at stage 3, plus Sop without Valid
      step(1, 1, 300, -400, 3, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      step(1, 0, -500, 600, 3, 0, 0);
      step(1, 0, 700, 800, 3, 0, 0);
      step(0, 0, 0, 0, 3, 0, 0);
      idle(3);

      // reset with two samples in flight
      step(1, 1, 1234, -4321, 4, 1, 0);
      step(1, 0, 2222, 3333, 4, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(4);
      step(1, 1, 50, 60, 0, 0, 0);
      idle(3);

      // random table and random traffic
      for (int k = 0; k < 256; k++)
         rom[k] = {$urandom_range(0, 1) == 1, 15'($urandom_range(0, 256)),
                   $urandom_range(0, 1) == 1, 15'($urandom_range(0, 256))};
      step(1, 1, 10, 20, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              int'($signed(r1)), int'($signed(r2)),
              $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom_range(0, 199) == 0);
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
